// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package ifetch_pkg;

    localparam int unsigned     XLEN       = 32;
    localparam int unsigned     FIFO_DEPTH = 2;
    localparam logic [XLEN-1:0] PC_STEP    = 32'd4;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALTED
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Bus bundle of the fetch controller: memory port, loader readback, redirect/halt and decode handshake.
interface imem_fetch_ctrl_if #(
    parameter int unsigned N = 32
);
    logic [N-1:0] mem_addr;
    logic [N-1:0] mem_rdata;
    logic         dbg_req;
    logic [N-1:0] dbg_addr;
    logic         dbg_gnt;
    logic         redirect;
    logic [N-1:0] redirect_pc;
    logic         halt;
    logic         dec_valid;
    logic         dec_ready;
    logic [N-1:0] dec_instr;
    logic [N-1:0] dec_pc;

    // Controller side.
    modport master (
        output mem_addr, dbg_gnt, dec_valid, dec_instr, dec_pc,
        input  mem_rdata, dbg_req, dbg_addr, redirect, redirect_pc, halt, dec_ready
    );

    // Memory, loader and pipeline side.
    modport slave (
        input  mem_addr, dbg_gnt, dec_valid, dec_instr, dec_pc,
        output mem_rdata, dbg_req, dbg_addr, redirect, redirect_pc, halt, dec_ready
    );

endinterface

// File: rtl/ifetch_fifo.sv
// Two-entry prefetch FIFO holding {pc, instr}; flush wins over push and pop.
module ifetch_fifo
    import ifetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    fetch_entry_t mem_q [FIFO_DEPTH];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;
    logic         do_push;
    logic         do_pop;

    assign full    = (count_q == 2'd2);
    assign empty   = (count_q == 2'd0);
    assign head    = mem_q[rd_ptr_q];
    assign do_pop  = pop & ~empty & ~flush;
    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_push = push & ~flush & (~full | do_pop);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) wr_ptr_q <= ~wr_ptr_q;
            if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    // NOTE: storage is not reset; the count alone defines validity and the head is masked when empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: PC sequencing, fixed-priority port sharing with the loader, prefetch FIFO.
// Optional IFETCH_PERF_EN adds perf_fetch_cnt / perf_stall_cnt outputs. N must equal ifetch_pkg::XLEN.
module imem_fetch_ctrl
    import ifetch_pkg::*;
#(
    parameter int unsigned N        = XLEN,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    imem_fetch_ctrl_if.master   bus
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]         perf_fetch_cnt,
    output logic [31:0]         perf_stall_cnt
`endif
);

    state_t       state_q, state_d;
    logic [N-1:0] pc_q, pc_d;
    logic         fifo_full, fifo_empty;
    fetch_entry_t fifo_head;
    fetch_entry_t push_entry;
    logic         pop;
    logic         fetch;
    logic         unused_redirect_lsbs;

    // The loader always wins the port; grant is suppressed while reset is asserted.
    assign bus.dbg_gnt  = bus.dbg_req & rst;
    assign bus.mem_addr = bus.dbg_gnt ? bus.dbg_addr : pc_q;

    assign pop   = ~fifo_empty & bus.dec_ready;
    assign fetch = (state_q == RUN) & ~bus.dbg_req & ~bus.redirect & (~fifo_full | pop);

    assign push_entry = '{pc: pc_q, instr: bus.mem_rdata};

    assign bus.dec_valid = ~fifo_empty;
    assign bus.dec_instr = fifo_empty ? '0 : fifo_head.instr;
    assign bus.dec_pc    = fifo_empty ? '0 : fifo_head.pc;

    assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

    ifetch_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fetch),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (bus.redirect),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (bus.halt)  state_d = HALTED;
            HALTED:  if (!bus.halt) state_d = RUN;
            default: state_d = BOOT;
        endcase
        if (bus.redirect) begin
            pc_d = {bus.redirect_pc[N-1:2], 2'b00};
        end else if (fetch) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

`ifdef IFETCH_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (fetch)                       perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if ((state_q == RUN) && !fetch)  perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed, table-driven bench for imem_fetch_ctrl; memory word at byte address a is a>>2.
module tb_imem_fetch_ctrl;

    typedef struct {
        logic        dbg_req;
        logic [31:0] dbg_addr;
        logic        redirect;
        logic [31:0] redirect_pc;
        logic        halt;
        logic        dec_ready;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic        exp_gnt;
        logic [31:0] exp_addr;
    } vec_t;

    logic clk;
    logic rst;
    logic rst2;
    int   n_vec  = 0;
    int   n_miss = 0;
    vec_t vecs[$];

    imem_fetch_ctrl_if #(.N(32)) bus ();
    imem_fetch_ctrl_if #(.N(32)) bus2 ();

    assign bus.mem_rdata  = bus.mem_addr >> 2;
    assign bus2.mem_rdata = bus2.mem_addr >> 2;

`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt, perf_fetch_cnt2, perf_stall_cnt2;
`endif

    imem_fetch_ctrl #(.N(32), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus)
`ifdef IFETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    imem_fetch_ctrl #(.N(32), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk            (clk),
        .rst            (rst2),
        .bus            (bus2)
`ifdef IFETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt2),
        .perf_stall_cnt (perf_stall_cnt2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic d, input logic [31:0] da, input logic r, input logic [31:0] ra,
                       input logic h, input logic rdy, input logic v, input logic [31:0] pc,
                       input logic g, input logic [31:0] a);
        vec_t t;
        t.dbg_req = d;   t.dbg_addr = da;  t.redirect = r;  t.redirect_pc = ra;
        t.halt = h;      t.dec_ready = rdy;
        t.exp_valid = v; t.exp_pc = pc;    t.exp_gnt = g;   t.exp_addr = a;
        vecs.push_back(t);
    endtask

    task automatic check_dec(input string tag, input logic v_act, input logic [31:0] pc_act,
                             input logic [31:0] in_act, input logic v, input logic [31:0] pc);
        check({tag, ".dec_valid"}, {31'd0, v_act}, {31'd0, v});
        check({tag, ".dec_pc"}, pc_act, v ? pc : 32'd0);
        check({tag, ".dec_instr"}, in_act, v ? (pc >> 2) : 32'd0);
    endtask

    // Expected sequence of the wrap-around instance after each reset release.
    logic        w_valid [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] w_pc    [5] = '{32'h0, 32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
    logic [31:0] w_addr  [5] = '{32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};

    initial begin
        // dbg, dbg_addr, redir, redir_pc, halt, ready | valid, pc, gnt, mem_addr
        add(0, 0, 0, 0, 0, 1,  0, 32'h00, 0, 32'h00);     // cycle 0: BOOT
        add(0, 0, 0, 0, 0, 1,  0, 32'h00, 0, 32'h00);     // first fetch
        add(0, 0, 0, 0, 0, 1,  1, 32'h00, 0, 32'h04);
        add(0, 0, 0, 0, 0, 1,  1, 32'h04, 0, 32'h08);
        add(0, 0, 0, 0, 0, 1,  1, 32'h08, 0, 32'h0C);
        add(0, 0, 0, 0, 0, 0,  1, 32'h0C, 0, 32'h10);     // decode stalls, FIFO fills
        for (int i = 0; i < 4; i++)
            add(0, 0, 0, 0, 0, 0,  1, 32'h0C, 0, 32'h14);
        add(0, 0, 0, 0, 0, 1,  1, 32'h0C, 0, 32'h14);     // push+pop while full
        add(0, 0, 0, 0, 0, 1,  1, 32'h10, 0, 32'h18);
        add(0, 0, 0, 0, 0, 1,  1, 32'h14, 0, 32'h1C);
        add(0, 0, 0, 0, 0, 1,  1, 32'h18, 0, 32'h20);
        add(0, 0, 1, 32'h93, 0, 1,  1, 32'h1C, 0, 32'h24); // redirect with full FIFO
        add(0, 0, 0, 0, 0, 1,  0, 32'h00, 0, 32'h90);
        add(0, 0, 0, 0, 0, 1,  1, 32'h90, 0, 32'h94);
        add(1, 32'h400, 0, 0, 0, 1,  1, 32'h94, 1, 32'h400); // loader owns port
        add(1, 32'h400, 0, 0, 0, 1,  0, 32'h00, 1, 32'h400);
        add(1, 32'h400, 0, 0, 0, 1,  0, 32'h00, 1, 32'h400);
        add(0, 0, 0, 0, 0, 1,  0, 32'h00, 0, 32'h98);     // resume at frozen pc
        add(0, 0, 0, 0, 0, 0,  1, 32'h98, 0, 32'h9C);
        add(1, 32'h400, 0, 0, 1, 0,  1, 32'h98, 1, 32'h400); // enter HALTED
        add(0, 0, 0, 0, 1, 1,  1, 32'h98, 0, 32'hA0);     // drain while halted
        add(0, 0, 0, 0, 1, 1,  1, 32'h9C, 0, 32'hA0);
        add(0, 0, 0, 0, 1, 1,  0, 32'h00, 0, 32'hA0);
        add(1, 32'h404, 0, 0, 1, 1,  0, 32'h00, 1, 32'h404);
        add(1, 32'h404, 0, 0, 0, 1,  0, 32'h00, 1, 32'h404); // leave HALTED
        add(0, 0, 0, 0, 0, 1,  0, 32'h00, 0, 32'hA0);
        add(0, 0, 0, 0, 0, 1,  1, 32'hA0, 0, 32'hA4);
        add(0, 0, 0, 0, 0, 1,  1, 32'hA4, 0, 32'hA8);
        add(1, 32'h408, 0, 0, 1, 1,  1, 32'hA8, 1, 32'h408);
        add(0, 0, 1, 32'h200, 1, 1,  0, 32'h00, 0, 32'hAC);  // redirect while halted
        add(1, 32'h40C, 0, 0, 0, 1,  0, 32'h00, 1, 32'h40C);
        add(0, 0, 0, 0, 0, 1,  0, 32'h00, 0, 32'h200);
        add(0, 0, 0, 0, 0, 1,  1, 32'h200, 0, 32'h204);

        rst = 1'b0;  rst2 = 1'b0;
        bus.dbg_req = 1'b1;  bus.dbg_addr = 32'h0000_0500;
        bus.redirect = 1'b0; bus.redirect_pc = '0; bus.halt = 1'b0; bus.dec_ready = 1'b1;
        bus2.dbg_req = 1'b0; bus2.dbg_addr = '0;
        bus2.redirect = 1'b0; bus2.redirect_pc = '0; bus2.halt = 1'b0; bus2.dec_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("reset.dbg_gnt", {31'd0, bus.dbg_gnt}, 32'd0);
        check("reset.mem_addr", bus.mem_addr, 32'h0);
        check_dec("reset", bus.dec_valid, bus.dec_pc, bus.dec_instr, 1'b0, 32'h0);
        bus.dbg_req = 1'b0;
        rst = 1'b1;

        foreach (vecs[i]) begin
            bus.dbg_req     = vecs[i].dbg_req;
            bus.dbg_addr    = vecs[i].dbg_addr;
            bus.redirect    = vecs[i].redirect;
            bus.redirect_pc = vecs[i].redirect_pc;
            bus.halt        = vecs[i].halt;
            bus.dec_ready   = vecs[i].dec_ready;
            #1;
            check_dec($sformatf("v%0d", i), bus.dec_valid, bus.dec_pc, bus.dec_instr,
                      vecs[i].exp_valid, vecs[i].exp_pc);
            check($sformatf("v%0d.dbg_gnt", i), {31'd0, bus.dbg_gnt}, {31'd0, vecs[i].exp_gnt});
            check($sformatf("v%0d.mem_addr", i), bus.mem_addr, vecs[i].exp_addr);
            @(posedge clk);
            #1;
        end
        bus.dbg_req = 1'b0; bus.redirect = 1'b0; bus.halt = 1'b0;

        // Wrap-around instance: PC wraps past 2^32, then an asynchronous reset mid-stream restarts it.
        for (int pass = 0; pass < 2; pass++) begin
            rst2 = 1'b1;
            for (int k = 0; k < 5; k++) begin
                #1;
                check_dec($sformatf("wrap%0d.c%0d", pass, k), bus2.dec_valid, bus2.dec_pc,
                          bus2.dec_instr, w_valid[k], w_pc[k]);
                check($sformatf("wrap%0d.c%0d.mem_addr", pass, k), bus2.mem_addr, w_addr[k]);
                @(posedge clk);
                #1;
            end
            if (pass == 0) begin
                #2;
                rst2 = 1'b0;
                #1;
                check_dec("async_rst", bus2.dec_valid, bus2.dec_pc, bus2.dec_instr, 1'b0, 32'h0);
                check("async_rst.mem_addr", bus2.mem_addr, 32'hFFFF_FFF8);
                @(posedge clk);
                #1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
